ones_acc: RTL and testbench

ONES_ACC -- requirements
Module: ones_acc

---
 rtl/ones_acc.sv | 124 ++++++++++++
 tb/tb_ones_acc.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ones_acc.sv
// Population-count stage: emits the number of set bits per word, or the
// saturating total over a frame of words, behind a single output register.
module ones_acc #(
    parameter int WIDTH = 16,
    parameter int ACC_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_count,
    output logic             out_sat
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_FRAME = 1'b1;

    localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};

    function automatic logic [ACC_W-1:0] popcount(input logic [WIDTH-1:0] d);
        logic [ACC_W-1:0] c;
        c = {ACC_W{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            c = c + {{(ACC_W-1){1'b0}}, d[i]};
        end
        return c;
    endfunction

    logic [0:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             flag_q, flag_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] out_count_q, out_count_d;
    logic             out_sat_q, out_sat_d;

    logic             beat_s;
    logic [ACC_W-1:0] pc_s;
    logic [ACC_W:0]   sum_s;
    logic             ovf_s;
    logic [ACC_W-1:0] sat_sum_s;

    assign in_ready  = !out_valid_q || out_ready;
    assign beat_s    = in_valid && in_ready;
    assign pc_s      = popcount(in_data);
    // One extra bit holds the carry; pc never exceeds ACC_MAX so this cannot overflow.
    assign sum_s     = {1'b0, acc_q} + {1'b0, pc_s};
    assign ovf_s     = sum_s[ACC_W];
    assign sat_sum_s = ovf_s ? ACC_MAX : sum_s[ACC_W-1:0];

    assign out_valid = out_valid_q;
    assign out_count = out_count_q;
    assign out_sat   = out_sat_q;

    // Next-state: frame tracking, saturating accumulation and output register load.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        flag_d      = flag_q;
        out_valid_d = out_valid_q && !out_ready;
        out_count_d = out_count_q;
        out_sat_d   = out_sat_q;
        if (beat_s) begin
            case (state_q)
                S_IDLE: begin
                    if (!mode || in_last) begin
                        out_valid_d = 1'b1;
                        out_count_d = pc_s;
                        out_sat_d   = 1'b0;
                    end else begin
                        acc_d   = pc_s;
                        flag_d  = 1'b0;
                        state_d = S_FRAME;
                    end
                end
                S_FRAME: begin
                    // mode is not consulted here: the frame type was fixed by its first word.
                    if (in_last) begin
                        out_valid_d = 1'b1;
                        out_count_d = sat_sum_s;
                        out_sat_d   = flag_q || ovf_s;
                        acc_d       = {ACC_W{1'b0}};
                        flag_d      = 1'b0;
                        state_d     = S_IDLE;
                    end else begin
                        acc_d  = sat_sum_s;
                        flag_d = flag_q || ovf_s;
                    end
                end
                default: begin
                    acc_d   = {ACC_W{1'b0}};
                    flag_d  = 1'b0;
                    state_d = S_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            acc_q       <= {ACC_W{1'b0}};
            flag_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_count_q <= {ACC_W{1'b0}};
            out_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            flag_q      <= flag_d;
            out_valid_q <= out_valid_d;
            out_count_q <= out_count_d;
            out_sat_q   <= out_sat_d;
        end
    end

endmodule

// File: tb/tb_ones_acc.sv
// Bench for ones_acc: a wide (ACC_W=12) and a narrow (ACC_W=5) instance share
// stimulus and are checked against a frame-total model using plain integers.
module tb_ones_acc;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_last, mode, out_ready;
    logic [15:0] in_data;
    logic        rdy_a, rdy_b, val_a, val_b, sat_a, sat_b;
    logic [11:0] cnt_a;
    logic [4:0]  cnt_b;

    always #5 clk = ~clk;

    ones_acc #(.WIDTH(16), .ACC_W(12)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_a), .in_data(in_data),
        .in_last(in_last), .mode(mode), .out_valid(val_a), .out_ready(out_ready),
        .out_count(cnt_a), .out_sat(sat_a));

    ones_acc #(.WIDTH(16), .ACC_W(5)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_b), .in_data(in_data),
        .in_last(in_last), .mode(mode), .out_valid(val_b), .out_ready(out_ready),
        .out_count(cnt_b), .out_sat(sat_b));

    int tests = 0;
    int fails = 0;

    // Model: whether a frame is open, its true (unclamped) total, and the pending result.
    bit m_open  = 1'b0;
    bit m_valid = 1'b0;
    int m_total = 0;
    int m_out   = 0;
    bit exp_rdy;
    logic obs_rdy_a, obs_rdy_b;

    function automatic int clamp(input int t, input int mx);
        return (t > mx) ? mx : t;
    endfunction

    task automatic model_reset();
        m_open  = 1'b0;
        m_valid = 1'b0;
        m_total = 0;
    endtask

    // Drive one cycle, capture in_ready before the edge, advance the model after it.
    task automatic apply(input bit v, input logic [15:0] d, input bit last, input bit m, input bit ordy);
        bit beat;
        bit produce;
        int pc;
        in_valid = v; in_data = d; in_last = last; mode = m; out_ready = ordy;
        #1;
        obs_rdy_a = rdy_a;
        obs_rdy_b = rdy_b;
        exp_rdy   = !m_valid || ordy;
        beat      = v && exp_rdy;
        produce   = 1'b0;
        pc        = $countones(d);
        @(posedge clk);
        #1;
        if (beat) begin
            if (!m_open) begin
                if (!m || last) begin
                    m_out = pc; produce = 1'b1;
                end else begin
                    m_open = 1'b1; m_total = pc;
                end
            end else begin
                m_total += pc;
                if (last) begin
                    m_out = m_total; m_open = 1'b0; produce = 1'b1;
                end
            end
        end
        if (produce) m_valid = 1'b1;
        else if (ordy) m_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = 16'h0000; in_last = 1'b0; mode = 1'b0; out_ready = 1'b0;
        #3;
        tests++;
        if (val_a !== 1'b0 || val_b !== 1'b0 || cnt_a !== 12'd0 || cnt_b !== 5'd0 || sat_a !== 1'b0 || sat_b !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: valid=%b/%b count=%0d/%0d sat=%b/%b, expected all zero", val_a, val_b, cnt_a, cnt_b, sat_a, sat_b);
        end
        tests++;
        if (rdy_a !== 1'b1 || rdy_b !== 1'b1) begin
            fails++; $display("FAIL reset_in_ready: got %b/%b expected 1", rdy_a, rdy_b);
        end
        #5 rst = 1'b0;
        model_reset();
    endtask

    task automatic test_per_word();
        logic [15:0] words [3];
        int          want  [3];
        words = '{16'h0000, 16'hFFFF, 16'hA5A5};
        want  = '{0, 16, 8};
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, words[i], 1'b1, 1'b0, 1'b1);
            tests++;
            if (obs_rdy_a !== 1'b1 || obs_rdy_b !== 1'b1) begin
                fails++; $display("FAIL per_word_ready[%0d]: got %b/%b expected 1", i, obs_rdy_a, obs_rdy_b);
            end
            tests++;
            if (val_a !== 1'b1 || int'(cnt_a) !== want[i] || int'(cnt_b) !== want[i] || sat_a !== 1'b0 || sat_b !== 1'b0) begin
                fails++;
                $display("FAIL per_word[%0d]: valid=%b count=%0d/%0d sat=%b/%b expected count %0d sat 0", i, val_a, cnt_a, cnt_b, sat_a, sat_b, want[i]);
            end
        end
        apply(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_frame();
        apply(1'b1, 16'h000F, 1'b0, 1'b1, 1'b1);
        apply(1'b1, 16'h00FF, 1'b0, 1'b1, 1'b1);
        tests++;
        if (val_a !== 1'b0 || val_b !== 1'b0) begin
            fails++; $display("FAIL frame_early_output: valid=%b/%b expected 0", val_a, val_b);
        end
        apply(1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b1);
        tests++;
        if (val_a !== 1'b1 || cnt_a !== 12'd28 || sat_a !== 1'b0) begin
            fails++; $display("FAIL frame_result: valid=%b count=%0d sat=%b expected 1/28/0", val_a, cnt_a, sat_a);
        end
        apply(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        tests++;
        if (val_a !== 1'b0) begin
            fails++; $display("FAIL frame_single_output: valid=%b expected 0", val_a);
        end
    endtask

    task automatic test_saturation();
        apply(1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b1);
        apply(1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b1);
        apply(1'b1, 16'h0001, 1'b1, 1'b1, 1'b1);
        tests++;
        if (val_b !== 1'b1 || cnt_b !== 5'd31 || sat_b !== 1'b1) begin
            fails++; $display("FAIL sat_narrow: valid=%b count=%0d sat=%b expected 1/31/1", val_b, cnt_b, sat_b);
        end
        tests++;
        if (cnt_a !== 12'd33 || sat_a !== 1'b0) begin
            fails++; $display("FAIL sat_wide: count=%0d sat=%b expected 33/0", cnt_a, sat_a);
        end
        apply(1'b1, 16'h0003, 1'b1, 1'b1, 1'b1);
        tests++;
        if (val_b !== 1'b1 || cnt_b !== 5'd2 || sat_b !== 1'b0) begin
            fails++; $display("FAIL sat_next_frame: valid=%b count=%0d sat=%b expected 1/2/0", val_b, cnt_b, sat_b);
        end
        apply(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_backpressure();
        apply(1'b1, 16'h00F0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            // A word offered during the stall must not be taken.
            apply(1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
            tests++;
            if (obs_rdy_a !== 1'b0 || val_a !== 1'b1 || cnt_a !== 12'd4 || cnt_b !== 5'd4) begin
                fails++;
                $display("FAIL backpressure_hold[%0d]: in_ready=%b valid=%b count=%0d/%0d expected 0/1/4/4", i, obs_rdy_a, val_a, cnt_a, cnt_b);
            end
        end
        apply(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        tests++;
        if (obs_rdy_a !== 1'b1 || val_a !== 1'b0 || val_b !== 1'b0) begin
            fails++; $display("FAIL backpressure_release: in_ready=%b valid=%b/%b expected 1/0/0", obs_rdy_a, val_a, val_b);
        end
    endtask

    task automatic test_reset_mid_frame();
        apply(1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b1);
        apply(1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b1);
        // Leave a stale result in the output register so the async clear is visible.
        #2 rst = 1'b1;
        #1;
        tests++;
        if (val_a !== 1'b0 || val_b !== 1'b0 || cnt_a !== 12'd0 || cnt_b !== 5'd0) begin
            fails++; $display("FAIL async_reset: valid=%b/%b count=%0d/%0d expected 0", val_a, val_b, cnt_a, cnt_b);
        end
        #1 rst = 1'b0;
        model_reset();
        apply(1'b1, 16'h0001, 1'b1, 1'b1, 1'b1);
        tests++;
        if (val_a !== 1'b1 || cnt_a !== 12'd1 || cnt_b !== 5'd1 || sat_b !== 1'b0) begin
            fails++; $display("FAIL post_reset_frame: valid=%b count=%0d/%0d sat=%b expected 1/1/1/0", val_a, cnt_a, cnt_b, sat_b);
        end
        apply(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_mode_toggle();
        apply(1'b1, 16'h00FF, 1'b0, 1'b1, 1'b1);
        apply(1'b1, 16'h0F0F, 1'b0, 1'b0, 1'b1);
        tests++;
        if (val_a !== 1'b0) begin
            fails++; $display("FAIL toggle_no_output: valid=%b expected 0", val_a);
        end
        apply(1'b1, 16'h0001, 1'b1, 1'b0, 1'b1);
        tests++;
        if (val_a !== 1'b1 || cnt_a !== 12'd17 || cnt_b !== 5'd17) begin
            fails++; $display("FAIL toggle_result: valid=%b count=%0d/%0d expected 1/17/17", val_a, cnt_a, cnt_b);
        end
        apply(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            apply(($urandom_range(0, 9) < 8), 16'($urandom), ($urandom_range(0, 3) == 0),
                  $urandom_range(0, 1) == 1, ($urandom_range(0, 3) != 0));
            tests++;
            if (obs_rdy_a !== exp_rdy || obs_rdy_b !== exp_rdy || val_a !== m_valid || val_b !== m_valid) begin
                fails++;
                $display("FAIL rand_handshake[%0d]: in_ready=%b/%b valid=%b/%b expected %b/%b", i, obs_rdy_a, obs_rdy_b, val_a, val_b, exp_rdy, m_valid);
            end
            if (m_valid) begin
                tests++;
                if (int'(cnt_a) !== clamp(m_out, 4095) || sat_a !== (m_out > 4095) ||
                    int'(cnt_b) !== clamp(m_out, 31) || sat_b !== (m_out > 31)) begin
                    fails++;
                    $display("FAIL rand_result[%0d]: count=%0d/%0d sat=%b/%b expected %0d/%0d %b/%b", i, cnt_a, cnt_b, sat_a, sat_b,
                             clamp(m_out, 4095), clamp(m_out, 31), m_out > 4095, m_out > 31);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_per_word();
        test_frame();
        test_saturation();
        test_backpressure();
        test_reset_mid_frame();
        test_mode_toggle();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
